schmitt_actuator_ctrl: RTL and testbench



---
 rtl/schmitt_actuator_ctrl.sv | 132 +++++++++++++
 tb/tb_schmitt_actuator_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/schmitt_actuator_ctrl.sv
// Actuator on/off controller behind a Schmitt trigger: min ON/OFF dwell, edge
// counting, and a latched safe-off fault when the actuator chatters inside a window.
module schmitt_actuator_ctrl #(
  parameter int CNT_W   = 8,
  parameter int WINDOW  = 64,
  parameter int MAX_TOG = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             trig_in,
  input  logic [CNT_W-1:0] min_on,
  input  logic [CNT_W-1:0] min_off,
  input  logic             fault_clr,
  output logic             act_out,
  output logic             busy,
  output logic             fault,
  output logic [15:0]      toggle_cnt
);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_ON    = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam int WIN_W = $clog2(WINDOW);
  localparam int TOG_W = $clog2(MAX_TOG + 2);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [TOG_W-1:0] TOG_LIMIT = TOG_W'(MAX_TOG);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] dwell_q, dwell_d, dwell_inc;
  logic             trig_q;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [TOG_W-1:0] win_tog_q, win_tog_d, tog_base;
  logic             act_q, act_d;
  logic             fault_q, fault_d;
  logic [15:0]      toggle_q, toggle_d;
  logic             win_wrap, tog_full;

  // The window clear on the wrap edge happens before a same-edge transition is counted.
  assign win_wrap  = (win_cnt_q == WIN_LAST);
  assign win_cnt_d = win_wrap ? '0 : win_cnt_q + 1'b1;
  assign tog_base  = win_wrap ? '0 : win_tog_q;
  assign tog_full  = (tog_base >= TOG_LIMIT);
  assign dwell_inc = (&dwell_q) ? dwell_q : dwell_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_inc;
    act_d     = act_q;
    fault_d   = fault_q;
    win_tog_d = tog_base;
    case (state_q)
      ST_OFF: begin
        if (en && trig_q && (dwell_q >= min_off)) begin
          dwell_d = '0;
          if (tog_full) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end else begin
            state_d   = ST_ON;
            act_d     = 1'b1;
            win_tog_d = tog_base + 1'b1;
          end
        end
      end
      ST_ON: begin
        // A forced off bypasses the dwell hold and is not chatter.
        if (!en) begin
          state_d = ST_OFF;
          act_d   = 1'b0;
          dwell_d = '0;
        end else if (!trig_q && (dwell_q >= min_on)) begin
          act_d   = 1'b0;
          dwell_d = '0;
          if (tog_full) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end else begin
            state_d   = ST_OFF;
            win_tog_d = tog_base + 1'b1;
          end
        end
      end
      ST_FAULT: begin
        dwell_d = '0;
        act_d   = 1'b0;
        if (fault_clr) begin
          state_d   = ST_OFF;
          fault_d   = 1'b0;
          win_tog_d = '0;
        end
      end
      default: begin
        state_d = ST_OFF;
        dwell_d = '0;
        act_d   = 1'b0;
        fault_d = 1'b0;
      end
    endcase
    toggle_d = (act_d != act_q) ? toggle_q + 16'd1 : toggle_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_OFF;
      dwell_q   <= '0;
      trig_q    <= 1'b0;
      win_cnt_q <= '0;
      win_tog_q <= '0;
      act_q     <= 1'b0;
      fault_q   <= 1'b0;
      toggle_q  <= '0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      trig_q    <= trig_in;
      win_cnt_q <= win_cnt_d;
      win_tog_q <= win_tog_d;
      act_q     <= act_d;
      fault_q   <= fault_d;
      toggle_q  <= toggle_d;
    end
  end

  assign busy = ((state_q == ST_OFF) && (dwell_q < min_off)) ||
                ((state_q == ST_ON)  && (dwell_q < min_on));
  assign act_out    = act_q;
  assign fault      = fault_q;
  assign toggle_cnt = toggle_q;

endmodule

// File: tb/tb_schmitt_actuator_ctrl.sv
// Bench for schmitt_actuator_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a timestamp-based reference model.
module tb_schmitt_actuator_ctrl;

  localparam int CNT_W   = 8;
  localparam int WINDOW  = 64;
  localparam int MAX_TOG = 4;
  localparam int DWELL_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, en, trig_in, fault_clr;
  logic [CNT_W-1:0] min_on, min_off;
  logic             act_out, busy, fault;
  logic [15:0]      toggle_cnt;

  // Reference model: outputs plus the edge index of the last state change and
  // the edge indices of every transition that counts toward chatter.
  int          k, lastChg;
  logic        actM, faultM, trigM;
  logic [15:0] togM;
  int          winq[$];

  int    compared   = 0;
  int    mismatched = 0;
  string phase      = "init";

  schmitt_actuator_ctrl #(.CNT_W(CNT_W), .WINDOW(WINDOW), .MAX_TOG(MAX_TOG)) dut (
    .clk(clk), .rst(rst), .en(en), .trig_in(trig_in),
    .min_on(min_on), .min_off(min_off), .fault_clr(fault_clr),
    .act_out(act_out), .busy(busy), .fault(fault), .toggle_cnt(toggle_cnt)
  );

  always #5 clk = ~clk;

  // One comparison: counts it, and reports and counts a failure.
  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  // Advances the model over one clock edge using the inputs present at that edge.
  task automatic modelStep();
    int dwell, wc;
    if (rst) begin
      k = 0; lastChg = 0; actM = 0; faultM = 0; trigM = 0; togM = '0;
      winq.delete();
    end else begin
      k++;
      dwell = k - 1 - lastChg;
      if (dwell > DWELL_MAX) dwell = DWELL_MAX;
      wc = 0;
      foreach (winq[i]) if (winq[i] / WINDOW == k / WINDOW) wc++;
      if (faultM) begin
        if (fault_clr) begin
          faultM = 0; lastChg = k; winq.delete();
        end
      end else if (!actM) begin
        if (en && trigM && dwell >= int'(min_off)) begin
          lastChg = k;
          if (wc >= MAX_TOG) faultM = 1;
          else begin actM = 1; togM++; winq.push_back(k); end
        end
      end else begin
        if (!en) begin
          actM = 0; togM++; lastChg = k;
        end else if (!trigM && dwell >= int'(min_on)) begin
          actM = 0; togM++; lastChg = k;
          if (wc >= MAX_TOG) faultM = 1;
          else winq.push_back(k);
        end
      end
      trigM = trig_in;
      while (winq.size() > 0 && winq[0] / WINDOW < k / WINDOW) void'(winq.pop_front());
    end
  endtask

  // Compares all outputs against the model; busy uses the dwell now held.
  task automatic checkOutput();
    int   d;
    logic busyExp;
    d = k - lastChg;
    if (d > DWELL_MAX) d = DWELL_MAX;
    busyExp = !faultM && (actM ? (d < int'(min_on)) : (d < int'(min_off)));
    cmp("act_out", act_out, actM);
    cmp("fault", fault, faultM);
    cmp("toggle_cnt", toggle_cnt, togM);
    cmp("busy", busy, busyExp);
  endtask

  // Drives one cycle of inputs, steps the model at the edge, checks at the falling edge.
  task automatic applyStimulus(input logic r, input logic e, input logic t,
                               input logic [CNT_W-1:0] mon, input logic [CNT_W-1:0] moff,
                               input logic clr);
    rst = r; en = e; trig_in = t; min_on = mon; min_off = moff; fault_clr = clr;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    logic rt;
    rst = 1; en = 0; trig_in = 0; fault_clr = 0; min_on = '0; min_off = '0;
    k = 0; lastChg = 0; actM = 0; faultM = 0; trigM = 0; togM = '0;

    // Reset release with min_off=3 and demand held: act_out rises on the 4th edge.
    phase = "reset";
    repeat (3) applyStimulus(1, 1, 1, 0, 3, 0);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(0, 1, 1, 0, 3, 0);
      if (i == 3) cmp("act_before_4", act_out, 0);
      if (i == 4) begin
        cmp("act_at_4", act_out, 1);
        cmp("toggles_at_4", toggle_cnt, 1);
      end
    end

    // No-hold latency: two-edge path from trig_in to act_out.
    phase = "latency";
    applyStimulus(1, 1, 0, 0, 0, 0);
    repeat (4) applyStimulus(0, 1, 0, 0, 0, 0);
    repeat (5) applyStimulus(0, 1, 1, 0, 0, 0);
    repeat (6) applyStimulus(0, 1, 0, 0, 0, 0);
    cmp("act_end", act_out, 0);
    cmp("toggles_end", toggle_cnt, 2);

    // Minimum ON hold of 10 cycles on a 2-cycle demand pulse.
    phase = "min_on";
    applyStimulus(1, 1, 0, 10, 0, 0);
    repeat (2) applyStimulus(0, 1, 1, 10, 0, 0);
    for (int i = 3; i <= 16; i++) begin
      applyStimulus(0, 1, 0, 10, 0, 0);
      if (i == 12) cmp("held_at_12", act_out, 1);
      if (i == 13) cmp("fell_at_13", act_out, 0);
    end

    // Forced off ignores a long min_on.
    phase = "forced";
    applyStimulus(1, 1, 0, 50, 0, 0);
    repeat (5) applyStimulus(0, 1, 1, 50, 0, 0);
    applyStimulus(0, 0, 1, 50, 0, 0);
    cmp("act_forced", act_out, 0);
    cmp("toggles_forced", toggle_cnt, 2);
    repeat (3) applyStimulus(0, 1, 1, 50, 0, 0);

    // Chatter: demand toggles every 2 cycles; 5th request latches the fault.
    phase = "chatter";
    applyStimulus(1, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) applyStimulus(0, 1, ((i - 1) % 4) < 2, 0, 0, 0);
    cmp("fault_set", fault, 1);
    cmp("act_safe", act_out, 0);
    cmp("toggles_chatter", toggle_cnt, 4);
    for (int i = 0; i < 10; i++) applyStimulus(0, $urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0);
    cmp("fault_sticky", fault, 1);
    applyStimulus(0, 1, 0, 0, 0, 1);
    repeat (4) applyStimulus(0, 1, 1, 0, 0, 0);
    cmp("fault_cleared", fault, 0);
    cmp("act_after_clr", act_out, 1);

    // Window wrap: 4 transitions late in window 0, a 5th on the wrap edge, no fault.
    phase = "wrap";
    applyStimulus(1, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 80; i++) begin
      rt = (i >= 55) && (((i - 55) % 4) < 2);
      applyStimulus(0, 1, rt, 0, 0, 0);
      if (i == 64) begin
        cmp("act_on_wrap", act_out, 1);
        cmp("no_fault_wrap", fault, 0);
      end
    end
    cmp("fault_window1", fault, 1);
    applyStimulus(1, 1, 1, 0, 0, 0);
    cmp("rst_fault", fault, 0);
    cmp("rst_toggles", toggle_cnt, 0);
    cmp("rst_act", act_out, 0);

    // Random traffic with occasional resets, clears and en drops.
    phase = "random";
    rt = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) rt = ~rt;
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 19) != 0, rt,
                    CNT_W'($urandom_range(0, 6)), CNT_W'($urandom_range(0, 6)),
                    $urandom_range(0, 9) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
